// File: rtl/regfile_write_scheduler_pkg.sv
// Shared CPU constants and requester identifiers for the register-file
// write scheduler and its round-robin arbiter.
package regfile_write_scheduler_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, and on contention the
// requester that did not win last time is granted.
module rr_arbiter2
  import regfile_write_scheduler_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_id_e last_grant;
  req_id_e winner;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else can leave a value unassigned and infer a latch.
  always_comb begin
    grant  = 2'b00;
    winner = last_grant;
    if (req[0] && req[1]) begin
      winner = (last_grant == REQ_ALU) ? REQ_MEM : REQ_ALU;
    end else if (req[1]) begin
      winner = REQ_MEM;
    end else begin
      winner = REQ_ALU;
    end
    if (enable && (|req)) begin
      grant = (winner == REQ_MEM) ? 2'b10 : 2'b01;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= REQ_ALU;
    end else if (|grant) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register file write port between ALU and load writeback and
// keeps a busy-bit scoreboard of destination registers with writes in flight.
module regfile_write_scheduler #(
  parameter int DATA_WIDTH = regfile_write_scheduler_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_write_scheduler_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = regfile_write_scheduler_pkg::NUM_REGS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_reg,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_reg,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_write,
  output logic [ADDR_WIDTH-1:0] rf_write_reg,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  input  logic                  reserve_valid,
  input  logic [ADDR_WIDTH-1:0] reserve_reg,
  input  logic [ADDR_WIDTH-1:0] query_reg1,
  input  logic [ADDR_WIDTH-1:0] query_reg2,
  output logic                  busy1,
  output logic                  busy2,
  output logic [ADDR_WIDTH:0]   pending_count,
  output logic                  stray_write
);

  import regfile_write_scheduler_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = ADDR_WIDTH'(ZERO_REG);

  logic [1:0]            grant;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;
  logic [ADDR_WIDTH:0]   busy_ones;
  logic                  stray_hit;

  // Grants are suppressed during reset so no request is consumed then.
  rr_arbiter2 u_arbiter (
    .clock  (clock),
    .reset  (reset),
    .enable (~reset),
    .req    ({req1_valid, req0_valid}),
    .grant  (grant)
  );

  assign req0_ready = grant[REQ_ALU];
  assign req1_ready = grant[REQ_MEM];
  assign accept     = |grant;
  assign sel_reg    = grant[REQ_MEM] ? req1_reg  : req0_reg;
  assign sel_data   = grant[REQ_MEM] ? req1_data : req0_data;

  // Clear at the commit edge, then set, so a same-edge reserve keeps the bit.
  always_comb begin
    busy_next = busy;
    if (rf_write) begin
      busy_next[rf_write_reg] = 1'b0;
    end
    if (reserve_valid && (reserve_reg != REG_ZERO)) begin
      busy_next[reserve_reg] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_comb begin
    busy_ones = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_ones = busy_ones + (ADDR_WIDTH + 1)'(busy[i]);
    end
  end

  // A write with no reservation behind it is flagged but still committed.
  assign stray_hit = accept && (sel_reg != REG_ZERO) && !busy[sel_reg] &&
                     !(reserve_valid && (reserve_reg == sel_reg));

  assign busy1 = busy[query_reg1];
  assign busy2 = busy[query_reg2];

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_write      <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      busy          <= '0;
      pending_count <= '0;
      stray_write   <= 1'b0;
    end else begin
      rf_write <= accept && (sel_reg != REG_ZERO);
      if (accept) begin
        rf_write_reg  <= sel_reg;
        rf_write_data <= sel_data;
      end
      busy          <= busy_next;
      pending_count <= busy_ones;
      if (stray_hit) begin
        stray_write <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench: readiness vectors from a table, committed writes
// matched against a queue of expected writes, plus hand-written corner cases.
module tb_regfile_write_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_reg, req1_reg;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          rf_write;
  logic [AW-1:0] rf_write_reg;
  logic [DW-1:0] rf_write_data;
  logic          reserve_valid;
  logic [AW-1:0] reserve_reg;
  logic [AW-1:0] query_reg1, query_reg2;
  logic          busy1, busy2;
  logic [AW:0]   pending_count;
  logic          stray_write;

  regfile_write_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_reg      (req0_reg),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_reg      (req1_reg),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .rf_write      (rf_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .reserve_valid (reserve_valid),
    .reserve_reg   (reserve_reg),
    .query_reg1    (query_reg1),
    .query_reg2    (query_reg2),
    .busy1         (busy1),
    .busy2         (busy2),
    .pending_count (pending_count),
    .stray_write   (stray_write)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] reg_idx;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic          v0;
    logic [AW-1:0] r0;
    logic          v1;
    logic [AW-1:0] r1;
    logic          e0;
    logic          e1;
  } vec_t;

  wr_t           exp_q[$];
  logic [DW-1:0] rf_model [NR];
  int            passed = 0;
  int            total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive both requesters, check readiness, and queue the write expected to follow.
  task automatic drive(input string name,
                       input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                       input logic e0, input logic e1);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    #1;
    check({name, "_ready0"}, 32'(req0_ready), 32'(e0));
    check({name, "_ready1"}, 32'(req1_ready), 32'(e1));
    if (e0 && r0 != 0) exp_q.push_back('{reg_idx: r0, data: d0});
    if (e1 && r1 != 0) exp_q.push_back('{reg_idx: r1, data: d1});
  endtask

  task automatic idle_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Every committed write must be the oldest queued expectation.
  always @(negedge clock) begin
    if (rf_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_reg", 32'(rf_write_reg), 32'hffff_ffff);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("commit_reg", 32'(rf_write_reg), 32'(w.reg_idx));
        check("commit_data", rf_write_data, w.data);
      end
    end
  end

  always @(posedge clock) begin
    if (rf_write === 1'b1 && rf_write_reg != 0) rf_model[rf_write_reg] <= rf_write_data;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{v0:1, r0:2,  v1:1, r1:3,  e0:0, e1:1};
    vecs[1] = '{v0:1, r0:2,  v1:0, r1:0,  e0:1, e1:0};
    vecs[2] = '{v0:1, r0:4,  v1:1, r1:6,  e0:0, e1:1};
    vecs[3] = '{v0:1, r0:4,  v1:1, r1:8,  e0:1, e1:0};
    vecs[4] = '{v0:0, r0:0,  v1:1, r1:8,  e0:0, e1:1};
    vecs[5] = '{v0:0, r0:0,  v1:0, r1:0,  e0:0, e1:0};
    vecs[6] = '{v0:1, r0:9,  v1:0, r1:0,  e0:1, e1:0};
    vecs[7] = '{v0:1, r0:10, v1:1, r1:12, e0:0, e1:1};
    vecs[8] = '{v0:1, r0:10, v1:0, r1:0,  e0:1, e1:0};

    for (int i = 0; i < NR; i++) rf_model[i] = '0;
    reset = 1'b1;
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h1;
    req1_valid = 1'b0; req1_reg = '0;   req1_data = '0;
    reserve_valid = 1'b0; reserve_reg = '0;
    query_reg1 = 5'd1; query_reg2 = 5'd2;

    // Reset, then idle
    step();
    check("ready0_in_reset", 32'(req0_ready), 32'd0);
    idle_reqs();
    step();
    reset = 1'b0;
    check("rst_rf_write", 32'(rf_write), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    check("rst_pending", 32'(pending_count), 32'd0);
    check("rst_stray", 32'(stray_write), 32'd0);

    // Single accepted write to reg 1
    reserve_valid = 1'b1; reserve_reg = 5'd1;
    step();
    reserve_valid = 1'b0;
    #1;
    check("single_busy_set", 32'(busy1), 32'd1);
    drive("single", 1, 5'd1, 32'haaaaaaaa, 0, 5'd0, 32'h0, 1, 0);
    step();
    idle_reqs();
    check("single_rf_write", 32'(rf_write), 32'd1);
    check("single_rf_reg", 32'(rf_write_reg), 32'd1);
    check("single_rf_data", rf_write_data, 32'haaaaaaaa);
    step();
    check("single_busy_clear", 32'(busy1), 32'd0);
    check("single_readback", rf_model[1], 32'haaaaaaaa);
    check("single_no_stray", 32'(stray_write), 32'd0);

    // Contention: req1 first (last grant was req0), then req0
    reserve_valid = 1'b1; reserve_reg = 5'd11;
    step();
    reserve_reg = 5'd31;
    step();
    reserve_valid = 1'b0;
    query_reg1 = 5'd11; query_reg2 = 5'd31;
    #1;
    check("cont_busy11", 32'(busy1), 32'd1);
    check("cont_busy31", 32'(busy2), 32'd1);
    drive("cont_a", 1, 5'd11, 32'hbbbbbbbb, 1, 5'd31, 32'hcccccccc, 0, 1);
    step();
    check("cont_pending_2", 32'(pending_count), 32'd2);
    check("cont_first_reg", 32'(rf_write_reg), 32'd31);
    drive("cont_b", 1, 5'd11, 32'hbbbbbbbb, 0, 5'd0, 32'h0, 1, 0);
    step();
    idle_reqs();
    check("cont_second_write", 32'(rf_write), 32'd1);
    check("cont_second_reg", 32'(rf_write_reg), 32'd11);
    step();
    check("cont_pending_1", 32'(pending_count), 32'd1);
    check("cont_gap", 32'(rf_write), 32'd0);
    step();
    check("cont_pending_0", 32'(pending_count), 32'd0);
    check("cont_clear11", 32'(busy1), 32'd0);
    check("cont_clear31", 32'(busy2), 32'd0);

    // Register 0 is consumed but never written
    drive("reg0", 1, 5'd0, 32'hdddddddd, 0, 5'd0, 32'h0, 1, 0);
    step();
    idle_reqs();
    check("reg0_no_write", 32'(rf_write), 32'd0);
    check("reg0_no_stray", 32'(stray_write), 32'd0);
    query_reg1 = 5'd0;
    #1;
    check("reg0_not_busy", 32'(busy1), 32'd0);

    // Set/clear collision on reg 5
    reserve_valid = 1'b1; reserve_reg = 5'd5;
    step();
    reserve_valid = 1'b0;
    drive("coll", 1, 5'd5, 32'h55555555, 0, 5'd0, 32'h0, 1, 0);
    step();
    idle_reqs();
    check("coll_write", 32'(rf_write), 32'd1);
    reserve_valid = 1'b1; reserve_reg = 5'd5;
    step();
    reserve_valid = 1'b0;
    query_reg2 = 5'd5;
    #1;
    check("coll_busy_kept", 32'(busy2), 32'd1);
    check("coll_pending_a", 32'(pending_count), 32'd1);
    step();
    check("coll_pending_b", 32'(pending_count), 32'd1);
    check("coll_no_stray", 32'(stray_write), 32'd0);

    // Stray write to unreserved reg 7
    drive("stray", 1, 5'd7, 32'h77777777, 0, 5'd0, 32'h0, 1, 0);
    step();
    idle_reqs();
    check("stray_set", 32'(stray_write), 32'd1);

    // Round-robin vectors (unreserved regs; stray stays set)
    for (int i = 0; i < 9; i++) begin
      drive($sformatf("vec%0d", i), vecs[i].v0, vecs[i].r0, 32'h1000_0000 + 32'(i),
            vecs[i].v1, vecs[i].r1, 32'h2000_0000 + 32'(i), vecs[i].e0, vecs[i].e1);
      step();
    end
    idle_reqs();
    check("stray_sticky", 32'(stray_write), 32'd1);
    check("pre_reset_write", 32'(rf_write), 32'd1);

    // Reset while a write is in the output stage
    reset = 1'b1;
    step();
    check("mrst_rf_write", 32'(rf_write), 32'd0);
    check("mrst_busy5", 32'(busy2), 32'd0);
    check("mrst_pending", 32'(pending_count), 32'd0);
    check("mrst_stray", 32'(stray_write), 32'd0);
    reset = 1'b0;
    step();
    step();
    check("mrst_no_pending", 32'(pending_count), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
